// File: rtl/bbus_dump_ctrl.sv
// bbus_dump_ctrl: debug snapshot controller for the B-bus source demux.
// On request it stalls the CPU at an instruction boundary and takes over the
// demux select. It walks sources 1..12 and streams 0xA5 followed by each
// 16-bit word (high byte first) on a valid/ready byte port.
//
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   dump_req    - start request, sampled in IDLE only
//   cpu_bflag   - demux select from the control unit (passthrough source)
//   cpu_idle    - CPU at an instruction boundary, bus safe to take
//   cpu_hold    - stall to the control unit
//   bflag       - select to the B-bus demux (combinational mux)
//   B_bus       - demux output, combinational from bflag
//   tx_data     - byte to transmitter
//   tx_valid    - byte valid
//   tx_ready    - transmitter accepts byte
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse when the dump completes
module bbus_dump_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_req,
    input  logic [3:0]  cpu_bflag,
    input  logic        cpu_idle,
    output logic        cpu_hold,
    output logic [3:0]  bflag,
    input  logic [15:0] B_bus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [SEL_W-1:0]  LAST_SRC = SEL_W'(12);
    localparam logic [BYTE_W-1:0] HDR_BYTE = BYTE_W'(8'hA5);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_HI   = 3'd4;
    localparam logic [2:0] S_LO   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [SEL_W-1:0]  idx;
    logic [SEL_W-1:0]  idx_next;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_next;
    logic              own;
    logic              own_next;
    logic [BYTE_W-1:0] tx_data_next;
    logic              tx_valid_next;
    logic              cpu_hold_next;
    logic              busy_next;
    logic              done_next;

    // Demux select: our walk index while we own the bus, CPU select otherwise.
    assign bflag = own ? idx : cpu_bflag;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            word     <= '0;
            own      <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            word     <= word_next;
            own      <= own_next;
            tx_data  <= tx_data_next;
            tx_valid <= tx_valid_next;
            cpu_hold <= cpu_hold_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        word_next     = word;
        own_next      = 1'b0;
        tx_data_next  = tx_data;
        tx_valid_next = 1'b0;
        cpu_hold_next = 1'b0;
        busy_next     = 1'b0;
        done_next     = 1'b0;

        case (state)
            S_IDLE: begin
                if (dump_req) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_idle) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (tx_ready) begin
                    idx_next   = SEL_W'(1);
                    state_next = S_CAP;
                end
            end
            S_CAP: begin
                // bflag has been stable on idx for a full cycle; B_bus has settled.
                word_next  = B_bus;
                state_next = S_HI;
            end
            S_HI: begin
                if (tx_ready) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (tx_ready) begin
                    if (idx == LAST_SRC) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx + SEL_W'(1);
                        state_next = S_CAP;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register in
        // step with it; tx_data is held when the byte is not being replaced,
        // which keeps it stable through a stall.
        case (state_next)
            S_HDR: begin
                tx_data_next  = HDR_BYTE;
                tx_valid_next = 1'b1;
            end
            S_HI: begin
                tx_data_next  = word_next[15:8];
                tx_valid_next = 1'b1;
            end
            S_LO: begin
                tx_data_next  = word_next[7:0];
                tx_valid_next = 1'b1;
            end
            default: begin
                tx_valid_next = 1'b0;
            end
        endcase

        own_next      = (state_next == S_HDR) || (state_next == S_CAP) ||
                        (state_next == S_HI)  || (state_next == S_LO);
        cpu_hold_next = own_next || (state_next == S_WAIT);
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_next == S_DONE);
    end

endmodule
